// File: rtl/tft_char_pkg.sv
// Shared timing constants, colours, output bundle type and the 8x16 font
// for the "FPGA TFT" character overlay.
package tft_char_pkg;

    // Horizontal timing, in pixel ticks
    localparam int H_SYNC  = 41;
    localparam int H_BACK  = 2;
    localparam int H_VALID = 480;
    localparam int H_FRONT = 2;
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;   // 525
    localparam int H_START = H_SYNC + H_BACK;                       // first active column
    localparam int H_END   = H_START + H_VALID;                     // one past last active

    // Vertical timing, in lines
    localparam int V_SYNC  = 10;
    localparam int V_BACK  = 2;
    localparam int V_VALID = 272;
    localparam int V_FRONT = 2;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;   // 286
    localparam int V_START = V_SYNC + V_BACK;
    localparam int V_END   = V_START + V_VALID;

    localparam int CNT_W = 10;   // holds 0..524
    localparam int POS_W = 9;    // holds active x 0..479, y 0..271

    // RGB565 colours
    localparam logic [15:0] COLOR_RED   = 16'hF800;
    localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
    localparam logic [15:0] COLOR_BLACK = 16'h0000;

    // Text box geometry: 8 glyphs of 8x16, each pixel doubled
    localparam int TEXT_LEN = 8;
    localparam int GLYPH_H  = 16;
    localparam int BOX_W    = 128;
    localparam int BOX_H    = 32;

    // Registered pixel-side outputs, updated together on each pixel tick
    typedef struct packed {
        logic [15:0] rgb;
        logic        hsync;
        logic        vsync;
        logic        de;
    } pix_out_t;

    // Font ROM in string order: F, P, G, A, space, T, F, T (MSB = leftmost pixel)
    localparam logic [7:0] FONT [TEXT_LEN][GLYPH_H] = '{
        '{8'h00, 8'h00, 8'hFE, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFC, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hFC, 8'h82, 8'h82, 8'h82, 8'h82, 8'hFC, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h7C, 8'h82, 8'h80, 8'h80, 8'h80, 8'h9E, 8'h82, 8'h82, 8'h82, 8'h86, 8'h7A, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h10, 8'h28, 8'h44, 8'h82, 8'h82, 8'hFE, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hFE, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hFE, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFC, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hFE, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00}
    };

    // One font pixel; col 0 is the leftmost (MSB) pixel of the glyph row
    function automatic logic font_bit(logic [2:0] idx, logic [3:0] row, logic [2:0] col);
        return FONT[idx][row][3'd7 - col];
    endfunction

endpackage

// File: rtl/tft_timing_gen.sv
// Pixel-clock divider plus horizontal/vertical scan counters for the
// 480x272 panel. Sync, DE and active x/y are combinational from the counters.
module tft_timing_gen
    import tft_char_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick,
    output logic             tft_clk,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y
);

    localparam int DIV_W = $clog2(DIV);

    logic [DIV_W-1:0] cnt_div;
    logic [DIV_W-1:0] cnt_div_next;
    logic [CNT_W-1:0] cnt_h;
    logic [CNT_W-1:0] cnt_v;

    // Tick on the last divider phase; compute the divider's next value
    always_comb begin
        tick         = (cnt_div == DIV_W'(DIV - 1));
        cnt_div_next = tick ? '0 : cnt_div + DIV_W'(1);
    end

    // Divider and pixel clock; tft_clk follows the updated count so it rises
    // DIV/2 cycles after the pixel outputs change
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch and
        // the edge list carries only the clock.
        if (!rst_n) begin
            cnt_div <= '0;
            tft_clk <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            cnt_div <= cnt_div_next;
            tft_clk <= (cnt_div_next >= DIV_W'(DIV / 2));
        end
    end

    // Scan counters: horizontal every tick, vertical at the end of each line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (tick) begin
            if (cnt_h == CNT_W'(H_TOTAL - 1)) begin
                cnt_h <= '0;
                cnt_v <= (cnt_v == CNT_W'(V_TOTAL - 1)) ? '0 : cnt_v + CNT_W'(1);
            end else begin
                cnt_h <= cnt_h + CNT_W'(1);
            end
        end
    end

    // Sync pulses, active-area flag and active-area coordinates
    always_comb begin
        // NOTE: every always_comb output gets a value before any branch, so no
        // path can leave it unassigned and infer a latch.
        x     = '0;
        y     = '0;
        hsync = (cnt_h < CNT_W'(H_SYNC));
        vsync = (cnt_v < CNT_W'(V_SYNC));
        de    = (cnt_h >= CNT_W'(H_START)) && (cnt_h < CNT_W'(H_END)) &&
                (cnt_v >= CNT_W'(V_START)) && (cnt_v < CNT_W'(V_END));
        if (de) begin
            x = POS_W'(cnt_h - CNT_W'(H_START));
            y = POS_W'(cnt_v - CNT_W'(V_START));
        end
    end

endmodule

// File: rtl/tft_char_top.sv
// Video timing plus "FPGA TFT" overlay for a 480x272 RGB565 panel.
// Build option: define TFT_CHAR_BORDER_EN to draw a one-pixel FG_COLOR frame
// around the active area.
module tft_char_top
    import tft_char_pkg::*;
#(
    parameter int          DIV      = 4,
    parameter logic [15:0] FG_COLOR = COLOR_RED,
    parameter logic [15:0] BG_COLOR = COLOR_WHITE,
    parameter int          CHAR_X   = 176,
    parameter int          CHAR_Y   = 120
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    output logic [15:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        tft_clk,
    output logic        tft_bl,
    output logic        tft_de
);

    logic             tick;
    logic             hsync_c;
    logic             vsync_c;
    logic             de_c;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             in_box;
    logic [6:0]       dx;
    logic [4:0]       dy;
    logic             glyph_on;
    logic [15:0]      color;
    pix_out_t         pix_next;
    pix_out_t         pix_q;

    tft_timing_gen #(
        .DIV (DIV)
    ) u_timing (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .tick    (tick),
        .tft_clk (tft_clk),
        .hsync   (hsync_c),
        .vsync   (vsync_c),
        .de      (de_c),
        .x       (x),
        .y       (y)
    );

    // Character renderer: map x/y into the doubled-up glyph grid and pick a colour
    always_comb begin
        in_box   = (x >= POS_W'(CHAR_X)) && (x < POS_W'(CHAR_X + BOX_W)) &&
                   (y >= POS_W'(CHAR_Y)) && (y < POS_W'(CHAR_Y + BOX_H));
        dx       = 7'(x - POS_W'(CHAR_X));
        dy       = 5'(y - POS_W'(CHAR_Y));
        glyph_on = in_box && font_bit(dx[6:4], dy[4:1], dx[3:1]);
        color    = glyph_on ? FG_COLOR : BG_COLOR;
`ifdef TFT_CHAR_BORDER_EN
        if ((x == '0) || (x == POS_W'(H_VALID - 1)) ||
            (y == '0) || (y == POS_W'(V_VALID - 1))) begin
            color = FG_COLOR;
        end
`endif
        pix_next.rgb   = de_c ? color : COLOR_BLACK;
        pix_next.hsync = hsync_c;
        pix_next.vsync = vsync_c;
        pix_next.de    = de_c;
    end

    // Pixel outputs load together on the tick, keeping rgb/sync/DE aligned
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pix_q <= '0;
        end else if (tick) begin
            pix_q <= pix_next;
        end
    end

    // Backlight turns on the first cycle out of reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tft_bl <= 1'b0;
        end else begin
            tft_bl <= 1'b1;
        end
    end

    assign rgb    = pix_q.rgb;
    assign hsync  = pix_q.hsync;
    assign vsync  = pix_q.vsync;
    assign tft_de = pix_q.de;

endmodule

// File: tb/tb_tft_char_top.sv
// Self-checking bench for tft_char_top. The reference model derives every
// output directly from the number of sys_clk edges since reset release.
// The text box is placed near the top of the screen and the divider
// shortened so the whole box is scanned in a short run.
module tb_tft_char_top;

    localparam int          T_DIV = 2;
    localparam int          T_CX  = 176;
    localparam int          T_CY  = 2;
    localparam logic [15:0] FG    = 16'hF800;
    localparam logic [15:0] BG    = 16'hFFFF;

    localparam logic [7:0] TEXT_STR [8] = '{"F", "P", "G", "A", " ", "T", "F", "T"};

    logic        sys_clk;
    logic        sys_rst_n;
    logic [15:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        tft_clk;
    logic        tft_bl;
    logic        tft_de;

    int checks = 0;
    int errors = 0;
    int k;

    logic hs_prev, vs_prev, de_prev, tc_prev;
    int   hs_rise0, vs_rise0, tc_rise0;
    bit   hs_w_done, hs_p_done, vs_w_done, tc_w_done, tc_p_done, de_done, hs_seen, tc_seen;

    typedef struct {
        logic [15:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic        tclk;
        logic        bl;
    } exp_t;

    tft_char_top #(
        .DIV      (T_DIV),
        .FG_COLOR (FG),
        .BG_COLOR (BG),
        .CHAR_X   (T_CX),
        .CHAR_Y   (T_CY)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rgb       (rgb),
        .hsync     (hsync),
        .vsync     (vsync),
        .tft_clk   (tft_clk),
        .tft_bl    (tft_bl),
        .tft_de    (tft_de)
    );

    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    // 8x16 bitmaps, row 0 in the top byte, MSB of each byte is the leftmost pixel
    function automatic logic [127:0] glyph_bits(logic [7:0] c);
        case (c)
            "F":     return 128'h0000FE80808080FC8080808080000000;
            "P":     return 128'h0000FC82828282FC8080808080000000;
            "G":     return 128'h00007C828080809E828282867A000000;
            "A":     return 128'h00001028448282FE8282828282000000;
            "T":     return 128'h0000FE10101010101010101010000000;
            default: return 128'h0;
        endcase
    endfunction

    function automatic logic [15:0] pixel(int x, int y);
        logic [127:0] g;
        int row;
        int col;
`ifdef TFT_CHAR_BORDER_EN
        if (x == 0 || x == 479 || y == 0 || y == 271) return FG;
`endif
        if (x >= T_CX && x < T_CX + 128 && y >= T_CY && y < T_CY + 32) begin
            g   = glyph_bits(TEXT_STR[(x - T_CX) / 16]);
            row = (y - T_CY) / 2;
            col = ((x - T_CX) / 2) % 8;
            return g[127 - 8 * row - col] ? FG : BG;
        end
        return BG;
    endfunction

    // Expected outputs after release edge number n (n = 0 is the first edge out of reset)
    function automatic exp_t model(int n);
        exp_t e;
        int m, h, v;
        e.rgb  = 16'h0;
        e.hs   = 1'b0;
        e.vs   = 1'b0;
        e.de   = 1'b0;
        e.bl   = 1'b1;
        e.tclk = (((n + 1) % T_DIV) >= T_DIV / 2);
        if (n >= T_DIV - 1) begin
            m    = (n - (T_DIV - 1)) / T_DIV;
            h    = m % 525;
            v    = (m / 525) % 286;
            e.hs = (h < 41);
            e.vs = (v < 10);
            e.de = (h >= 43 && h <= 522 && v >= 12 && v <= 283);
            if (e.de) e.rgb = pixel(h - 43, v - 12);
        end
        return e;
    endfunction

    task automatic check_val(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check_val("rst_rgb", rgb, 16'h0);
        check_val("rst_hsync", 16'(hsync), 16'h0);
        check_val("rst_vsync", 16'(vsync), 16'h0);
        check_val("rst_de", 16'(tft_de), 16'h0);
        check_val("rst_tft_clk", 16'(tft_clk), 16'h0);
        check_val("rst_tft_bl", 16'(tft_bl), 16'h0);
    endtask

    task automatic clear_tracking();
        hs_prev = 1'b0;
        vs_prev = 1'b0;
        de_prev = 1'b0;
        tc_prev = 1'b0;
        k       = 0;
    endtask

    // Wait one sys_clk cycle, compare all outputs to the model, track pulse widths
    task automatic step_and_check();
        exp_t e;
        @(negedge sys_clk);
        e = model(k);
        check_val("rgb", rgb, e.rgb);
        check_val("hsync", 16'(hsync), 16'(e.hs));
        check_val("vsync", 16'(vsync), 16'(e.vs));
        check_val("tft_de", 16'(tft_de), 16'(e.de));
        check_val("tft_clk", 16'(tft_clk), 16'(e.tclk));
        check_val("tft_bl", 16'(tft_bl), 16'(e.bl));
        if (!tft_de) check_val("rgb_blank", rgb, 16'h0);

        if (hsync && !hs_prev) begin
            if (!hs_seen) begin
                hs_seen  = 1'b1;
                hs_rise0 = k;
            end else if (!hs_p_done) begin
                hs_p_done = 1'b1;
                check_int("hsync_period", k - hs_rise0, 525 * T_DIV);
            end
        end
        if (!hsync && hs_prev && !hs_w_done) begin
            hs_w_done = 1'b1;
            check_int("hsync_width", k - hs_rise0, 41 * T_DIV);
        end
        if (vsync && !vs_prev) vs_rise0 = k;
        if (!vsync && vs_prev && !vs_w_done) begin
            vs_w_done = 1'b1;
            check_int("vsync_width", k - vs_rise0, 10 * 525 * T_DIV);
        end
        if (tft_de && !de_prev && !de_done) begin
            de_done = 1'b1;
            check_int("first_de_edge", k, T_DIV - 1 + T_DIV * (12 * 525 + 43));
        end
        if (tft_clk && !tc_prev) begin
            if (!tc_seen) begin
                tc_seen  = 1'b1;
                tc_rise0 = k;
            end else if (!tc_p_done) begin
                tc_p_done = 1'b1;
                check_int("tft_clk_period", k - tc_rise0, T_DIV);
            end
        end
        if (!tft_clk && tc_prev && tc_seen && !tc_w_done) begin
            tc_w_done = 1'b1;
            check_int("tft_clk_high", k - tc_rise0, T_DIV / 2);
        end

        hs_prev = hsync;
        vs_prev = vsync;
        de_prev = tft_de;
        tc_prev = tft_clk;
        k++;
    endtask

    initial begin
        int extra;
        int hold;
        hs_w_done = 1'b0; hs_p_done = 1'b0; vs_w_done = 1'b0;
        tc_w_done = 1'b0; tc_p_done = 1'b0; de_done   = 1'b0;
        hs_seen   = 1'b0; tc_seen   = 1'b0;
        hs_rise0  = 0; vs_rise0 = 0; tc_rise0 = 0;
        clear_tracking();

        // Power-up reset for one edge
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check_reset_state();
        sys_rst_n = 1'b1;

        // Scan through the sync periods, first active rows and the whole text box
        repeat (47 * 525 * T_DIV) step_and_check();

        // Event-count sanity: every one-shot measurement was reached
        check_int("measurements_seen",
                  int'(hs_w_done) + int'(hs_p_done) + int'(vs_w_done) +
                  int'(tc_w_done) + int'(tc_p_done) + int'(de_done), 6);

        // Random extra run, then a mid-frame reset of random length
        extra = $urandom_range(200, 3000);
        repeat (extra) step_and_check();
        sys_rst_n = 1'b0;
        hold = $urandom_range(1, 4);
        repeat (hold) begin
            @(negedge sys_clk);
            check_reset_state();
        end
        sys_rst_n = 1'b1;
        clear_tracking();

        // Timing restarts from the top-left after the second release
        repeat (3 * 525 * T_DIV + $urandom_range(0, 500)) step_and_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
